gpu_mem_server: RTL and testbench

GPU_MEM_SERVER -- requirements
Module: gpu_mem_server

---
 rtl/gpu_mem_pkg.sv | 20 ++
 rtl/vec_mem_array.sv | 38 +++
 rtl/gpu_mem_server.sv | 160 ++++++++++++++++
 tb/tb_gpu_mem_server.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared constants, FSM state and host command encoding
package gpu_mem_pkg;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 18;
  localparam int LANES = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_DUMP = 2'b10;
  localparam logic [1:0] CMD_RUN  = 2'b11;

endpackage

// File: rtl/vec_mem_array.sv
// rtl/vec_mem_array.sv - multi-lane memory, async reads, prioritised writes
module vec_mem_array
  import gpu_mem_pkg::*;
#(
  parameter int D  = DEPTH,
  parameter int W  = WIDTH,
  parameter int L  = LANES,
  parameter int AW = $clog2(D)
) (
  input  logic                  clk,
  input  logic [L-1:0][AW-1:0]  raddr,
  output logic [L-1:0][W-1:0]   rdata,
  input  logic [L-1:0]          we,
  input  logic [L-1:0][AW-1:0]  waddr,
  input  logic [L-1:0][W-1:0]   wdata
);

  // Contents survive reset; the host reloads them explicitly when needed.
  logic [W-1:0] mem [D];

  // Asynchronous read: each lane sees the pre-edge contents of its address.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < L; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

  // Lanes are applied in ascending order so a higher lane overrides a lower one on the same address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      if (we[i]) begin
        mem[waddr[i]] <= wdata[i];
      end
    end
  end

endmodule

// File: rtl/gpu_mem_server.sv
// rtl/gpu_mem_server.sv - host load/dump/run controller around a 3-lane GPU memory
module gpu_mem_server
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH_P = DEPTH,
  parameter int WIDTH_P = WIDTH,
  parameter int LANES_P = LANES,
  localparam int AW     = $clog2(DEPTH_P)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [AW-1:0]                    A1,
  input  logic [AW-1:0]                    A2,
  input  logic [AW-1:0]                    A3,
  input  logic                             MemWriteM,
  input  logic [LANES_P-1:0][WIDTH_P-1:0]  writeData,
  output logic [LANES_P-1:0][WIDTH_P-1:0]  ReadData,
  output logic                             gpu_en,
  input  logic [1:0]                       host_cmd,
  input  logic                             host_cmd_valid,
  input  logic [AW-1:0]                    host_len,
  input  logic [WIDTH_P-1:0]               in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH_P-1:0]               out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             done
);

  state_e      state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] len_m1;
  logic          tail;
  logic          load_fire;
  logic          dump_adv;

  logic [LANES_P-1:0][AW-1:0]      raddr;
  logic [LANES_P-1:0][WIDTH_P-1:0] rdata;
  logic [LANES_P-1:0]              we;
  logic [LANES_P-1:0][AW-1:0]      waddr;
  logic [LANES_P-1:0][WIDTH_P-1:0] wdata;

  assign gpu_en    = (state == ST_RUN);
  assign in_ready  = (state == ST_LOAD);
  assign load_fire = in_ready && in_valid;
  assign dump_adv  = (state == ST_DUMP) && (!out_valid || out_ready);

  // Lane 0 is shared: the GPU drives it in RUN, the host counter drives it otherwise.
  always_comb begin
    raddr = '0;
    waddr = '0;
    wdata = '0;
    we    = '0;
    for (int i = 0; i < LANES_P; i++) begin
      raddr[i] = (i == 1) ? A2 : (i == 2) ? A3 : A1;
      waddr[i] = raddr[i];
      wdata[i] = writeData[i];
      we[i]    = gpu_en && MemWriteM;
    end
    if (!gpu_en) begin
      raddr[0] = cnt;
      waddr[0] = cnt;
      wdata[0] = in_data;
      we[0]    = load_fire;
    end
  end

  // The GPU only sees memory data while it owns the array.
  always_comb begin
    ReadData = '0;
    if (gpu_en) begin
      ReadData = rdata;
    end
  end

  vec_mem_array #(
    .D  (DEPTH_P),
    .W  (WIDTH_P),
    .L  (LANES_P),
    .AW (AW)
  ) u_mem (
    .clk   (CLK),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  // Host command FSM; len_m1 wraps so a zero length means a full 2^AW transfer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_m1    <= '0;
      tail      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_cmd_valid) begin
            case (host_cmd)
              CMD_LOAD: begin
                len_m1 <= host_len - AW'(1);
                cnt    <= '0;
                state  <= ST_LOAD;
              end
              CMD_DUMP: begin
                len_m1 <= host_len - AW'(1);
                cnt    <= '0;
                tail   <= 1'b0;
                state  <= ST_DUMP;
              end
              CMD_RUN:  state <= ST_RUN;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            cnt <= cnt + AW'(1);
            if (cnt == len_m1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (dump_adv) begin
            if (tail) begin
              out_valid <= 1'b0;
              tail      <= 1'b0;
              state     <= ST_IDLE;
              done      <= 1'b1;
            end else begin
              out_data  <= rdata[0];
              out_valid <= 1'b1;
              cnt       <= cnt + AW'(1);
              if (cnt == len_m1) begin
                tail <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (host_cmd_valid && host_cmd == CMD_STOP) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_mem_server.sv
// tb/tb_gpu_mem_server.sv - directed self-checking bench for gpu_mem_server
module tb_gpu_mem_server;

  logic              CLK;
  logic              RST;
  logic [9:0]        A1, A2, A3;
  logic              MemWriteM;
  logic [2:0][17:0]  writeData;
  logic [2:0][17:0]  ReadData;
  logic              gpu_en;
  logic [1:0]        host_cmd;
  logic              host_cmd_valid;
  logic [9:0]        host_len;
  logic [17:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [17:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [9:0]  a1, a2, a3;
    logic        we;
    logic [17:0] wd0, wd1, wd2;
    logic        chk;
    logic [17:0] e0, e1, e2;
  } vec_t;

  vec_t vecs[9];

  gpu_mem_server dut (
    .CLK            (CLK),
    .RST            (RST),
    .A1             (A1),
    .A2             (A2),
    .A3             (A3),
    .MemWriteM      (MemWriteM),
    .writeData      (writeData),
    .ReadData       (ReadData),
    .gpu_en         (gpu_en),
    .host_cmd       (host_cmd),
    .host_cmd_valid (host_cmd_valid),
    .host_len       (host_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .done           (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input logic [9:0] len);
    host_cmd       = cmd;
    host_len       = len;
    host_cmd_valid = 1'b1;
    next_cycle();
    host_cmd_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int dones;

    vecs[0] = '{10'd10, 10'd11, 10'd12, 1'b1, 18'h10a, 18'h10b, 18'h10c, 1'b0, 18'h0, 18'h0, 18'h0};
    vecs[1] = '{10'd12, 10'd11, 10'd10, 1'b0, 18'h0, 18'h0, 18'h0, 1'b1, 18'h10c, 18'h10b, 18'h10a};
    vecs[2] = '{10'd5, 10'd5, 10'd5, 1'b1, 18'h1, 18'h2, 18'h3, 1'b0, 18'h0, 18'h0, 18'h0};
    vecs[3] = '{10'd5, 10'd10, 10'd5, 1'b0, 18'h0, 18'h0, 18'h0, 1'b1, 18'h3, 18'h10a, 18'h3};
    vecs[4] = '{10'd20, 10'd20, 10'd21, 1'b1, 18'h111, 18'h222, 18'h333, 1'b0, 18'h0, 18'h0, 18'h0};
    vecs[5] = '{10'd20, 10'd21, 10'd20, 1'b1, 18'h3ffff, 18'h1, 18'h2, 1'b1, 18'h222, 18'h333, 18'h222};
    vecs[6] = '{10'd20, 10'd21, 10'd0, 1'b0, 18'h0, 18'h0, 18'h0, 1'b1, 18'h2, 18'h1, 18'h11};
    vecs[7] = '{10'd7, 10'd7, 10'd7, 1'b1, 18'h77, 18'h77, 18'h77, 1'b0, 18'h0, 18'h0, 18'h0};
    vecs[8] = '{10'd7, 10'd5, 10'd11, 1'b0, 18'h0, 18'h0, 18'h0, 1'b1, 18'h77, 18'h3, 18'h10b};

    RST = 1'b0;
    A1 = '0; A2 = '0; A3 = '0;
    MemWriteM = 1'b0; writeData = '0;
    host_cmd = 2'b00; host_cmd_valid = 1'b0; host_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_gpu_en", gpu_en, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_data", out_data, 18'h0);
    check("rst_readdata", ReadData, 54'h0);
    @(negedge CLK);
    RST = 1'b1;
    next_cycle();

    // LOAD len=4, continuous in_valid; done in the 5th cycle after the command edge
    send_cmd(2'b01, 10'd4);
    check("load_in_ready", in_ready, 1'b1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      in_data  = 18'h11 + 18'(k);
      in_valid = 1'b1;
      if (done !== 1'b0 || in_ready !== 1'b1) bad++;
      next_cycle();
    end
    in_valid = 1'b0;
    check("load4_early_done_or_stall", bad, 0);
    check("load4_done", done, 1'b1);
    check("load4_back_idle", in_ready, 1'b0);
    next_cycle();
    check("load4_done_one_cycle", done, 1'b0);

    // DUMP len=3 with out_ready 1,0,1,1 once data is valid
    send_cmd(2'b10, 10'd3);
    check("dump_first_not_yet", out_valid, 1'b0);
    out_ready = 1'b1;
    next_cycle();
    check("dump_w0_valid", out_valid, 1'b1);
    check("dump_w0", out_data, 18'h11);
    next_cycle();
    out_ready = 1'b0;
    check("dump_w1", out_data, 18'h12);
    next_cycle();
    out_ready = 1'b1;
    check("dump_w1_held_valid", out_valid, 1'b1);
    check("dump_w1_held", out_data, 18'h12);
    check("dump_no_early_done", done, 1'b0);
    next_cycle();
    check("dump_w2", out_data, 18'h13);
    check("dump_w2_valid", out_valid, 1'b1);
    next_cycle();
    out_ready = 1'b0;
    check("dump_end_valid", out_valid, 1'b0);
    check("dump_done", done, 1'b1);

    // RUN table: conflicts, read-before-write, multi-lane reads
    send_cmd(2'b11, 10'd0);
    check("run_gpu_en", gpu_en, 1'b1);
    for (int i = 0; i < 9; i++) begin
      A1 = vecs[i].a1; A2 = vecs[i].a2; A3 = vecs[i].a3;
      MemWriteM = vecs[i].we;
      writeData = {vecs[i].wd2, vecs[i].wd1, vecs[i].wd0};
      #1;
      if (vecs[i].chk) begin
        check($sformatf("run_v%0d_lane0", i), ReadData[0], vecs[i].e0);
        check($sformatf("run_v%0d_lane1", i), ReadData[1], vecs[i].e1);
        check($sformatf("run_v%0d_lane2", i), ReadData[2], vecs[i].e2);
      end
      next_cycle();
    end
    MemWriteM = 1'b0;

    // A LOAD command during RUN is ignored
    send_cmd(2'b01, 10'd2);
    check("run_ignores_load", gpu_en, 1'b1);
    check("run_ignores_load_ready", in_ready, 1'b0);

    send_cmd(2'b00, 10'd0);
    check("stop_gpu_en", gpu_en, 1'b0);
    check("stop_done", done, 1'b1);

    // IDLE: writes ignored, ReadData forced to zero
    A1 = 10'd7; A2 = 10'd7; A3 = 10'd7;
    writeData = {18'h1234, 18'h1234, 18'h1234};
    MemWriteM = 1'b1;
    #1;
    check("idle_readdata_zero", ReadData, 54'h0);
    next_cycle();
    MemWriteM = 1'b0;
    send_cmd(2'b11, 10'd0);
    check("idle_write_ignored", ReadData[0], 18'h77);
    send_cmd(2'b00, 10'd0);

    // LOAD len=0 transfers 1024 words with exactly one done
    send_cmd(2'b01, 10'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      in_data  = 18'(i * 3 + 256);
      in_valid = 1'b1;
      if (in_ready !== 1'b1 || done !== 1'b0) bad++;
      next_cycle();
    end
    in_valid = 1'b0;
    check("load1024_accept_all", bad, 0);
    check("load1024_done", done, 1'b1);
    check("load1024_stopped", in_ready, 1'b0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (done === 1'b1) dones++;
    end
    check("load1024_single_done", dones, 0);

    // Reset after 2 of 4 LOAD words
    send_cmd(2'b01, 10'd4);
    in_valid = 1'b1;
    in_data  = 18'h2a;
    next_cycle();
    in_data  = 18'h2b;
    next_cycle();
    in_valid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    #3;
    RST = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (done !== 1'b0 || in_ready !== 1'b0) dones++;
    end
    check("midrst_no_done_idle", dones, 0);

    send_cmd(2'b11, 10'd0);
    A1 = 10'd0; A2 = 10'd1; A3 = 10'd2;
    #1;
    check("midrst_mem0", ReadData[0], 18'h2a);
    check("midrst_mem1", ReadData[1], 18'h2b);
    check("midrst_mem2", ReadData[2], 18'h106);
    A1 = 10'd1023;
    #1;
    check("load1024_last_word", ReadData[0], 18'(1023 * 3 + 256));
    send_cmd(2'b00, 10'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
